// File: rtl/ipsxe_fft_pkg.sv
// ipsxe_fft_pkg
// Shared definitions for the FFT reorder path.
//   rd_state_e : reader FSM encoding (RD_IDLE, RD_RUN)
//   bitrev()   : reverses the low 'width' bits of a value (width <= BITREV_MAX_W)
package ipsxe_fft_pkg;

    localparam int unsigned BITREV_MAX_W = 9;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

    // Reverse the whole container, then shift the reversed field down so that
    // only the low 'width' bits of 'val' take part in the reversal.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] val,
        input int unsigned             width
    );
        logic [BITREV_MAX_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            rev[i] = val[BITREV_MAX_W-1-i];
        end
        return rev >> (BITREV_MAX_W - width);
    endfunction

endpackage

// File: rtl/ipsxe_fft_reorder_bank_cnt.sv
// ipsxe_fft_reorder_bank_cnt
// Sample counter with terminal count and ping-pong bank select.
//   clk, rst : clock, synchronous active-high reset
//   inc      : advance the counter by one this cycle
//   cnt      : current position within the frame
//   bank     : bank currently addressed
//   tc       : cnt is at the last position of the frame
//   wrap     : inc while tc; bank toggles and cnt returns to 0
module ipsxe_fft_reorder_bank_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         bank,
    output logic         tc,
    output logic         wrap
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         bank_q, bank_d;

    assign cnt  = cnt_q;
    assign bank = bank_q;
    assign tc   = &cnt_q;
    assign wrap = inc & tc;

    always_comb begin
        cnt_d  = cnt_q;
        bank_d = bank_q;
        if (inc) begin
            cnt_d = cnt_q + W'(1);   // natural modulo-N wrap
        end
        if (wrap) begin
            bank_d = ~bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bank_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bank_q <= bank_d;
        end
    end

endmodule

// File: rtl/ipsxe_fft_reorder_ctrl.sv
// ipsxe_fft_reorder_ctrl
// Ping-pong bit-reversal reorder controller. Frames are written in natural
// order into one half of an external 2*N word RAM while the other half is read
// out in bit-reversed order.
//   s_valid/s_ready/s_data/s_last : input stream (s_last only checked)
//   m_valid/m_ready/m_data/m_last : output stream, m_data is the RAM output register
//   frm_err                       : s_last disagreed with the write count
//   ram_wr_* / ram_rd_*           : write and read ports of the external RAM
module ipsxe_fft_reorder_ctrl
    import ipsxe_fft_pkg::*;
#(
    parameter int LOG2_N     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  frm_err,
    output logic                  ram_wr_en,
    output logic [LOG2_N:0]       ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [LOG2_N:0]       ram_rd_addr,
    output logic                  ram_rd_clken,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    logic [1:0]  full_q, full_d;
    rd_state_e   state_q, state_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;

    logic              wr_fire, wr_bank, wr_tc, wr_wrap;
    logic [LOG2_N-1:0] wr_cnt;
    logic              rd_issue, rd_bank, rd_tc, rd_wrap;
    logic [LOG2_N-1:0] rd_cnt;
    logic              adv;

    ipsxe_fft_reorder_bank_cnt #(.W(LOG2_N)) u_wr_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (wr_fire),
        .cnt  (wr_cnt),
        .bank (wr_bank),
        .tc   (wr_tc),
        .wrap (wr_wrap)
    );

    ipsxe_fft_reorder_bank_cnt #(.W(LOG2_N)) u_rd_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (rd_issue),
        .cnt  (rd_cnt),
        .bank (rd_bank),
        .tc   (rd_tc),
        .wrap (rd_wrap)
    );

    assign s_ready = ~full_q[wr_bank];
    assign wr_fire = s_valid & s_ready;
    assign frm_err = wr_fire & (s_last != wr_tc);

    // The read output register only moves when the consumer can take a word.
    assign adv = ~m_valid_q | m_ready;
    // A bank that just became full is readable in the same cycle the FSM
    // leaves RD_IDLE, which gives the two-cycle input-to-output latency.
    assign rd_issue = adv & ((state_q == RD_RUN) | full_q[rd_bank]);

    assign ram_wr_en    = wr_fire;
    assign ram_wr_addr  = {wr_bank, wr_cnt};
    assign ram_wr_data  = s_data;
    assign ram_rd_addr  = {rd_bank, LOG2_N'(bitrev(BITREV_MAX_W'(rd_cnt), LOG2_N))};
    assign ram_rd_clken = adv;

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = ram_rd_data;

    always_comb begin
        full_d    = full_q;
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;

        // Set and clear always hit different banks, so both can apply.
        if (wr_wrap) begin
            full_d[wr_bank] = 1'b1;
        end
        if (rd_wrap) begin
            full_d[rd_bank] = 1'b0;
        end

        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank]) begin
                    state_d = RD_RUN;
                end
            end
            RD_RUN: begin
                if (rd_wrap) begin
                    state_d = full_q[~rd_bank] ? RD_RUN : RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase

        if (adv) begin
            m_valid_d = rd_issue;
            m_last_d  = rd_issue & rd_tc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 2'b00;
            state_q   <= RD_IDLE;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            full_q    <= full_d;
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

endmodule

// File: tb/tb_ipsxe_fft_reorder_ctrl.sv
module tb_ipsxe_fft_reorder_ctrl;

    localparam int LOG2_N = 4;
    localparam int N      = 16;
    localparam int DW     = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          frm_err;
    logic          ram_wr_en;
    logic [4:0]    ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [4:0]    ram_rd_addr;
    logic          ram_rd_clken;
    logic [DW-1:0] ram_rd_data;

    ipsxe_fft_reorder_ctrl #(.LOG2_N(LOG2_N), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .frm_err      (frm_err),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_clken (ram_rd_clken),
        .ram_rd_data  (ram_rd_data)
    );

    always #5 clk = ~clk;

    // RAM model: simple dual port, registered read output with clock enable
    logic [DW-1:0] mem [0:31];
    always @(posedge clk) begin
        if (ram_wr_en)    mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_clken) ram_rd_data      <= mem[ram_rd_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] part[N];
    int            part_n = 0;
    int            err_pulses = 0;
    int            last_in_cyc = 0;
    int            out_cycs[$];
    logic [DW-1:0] out_dat[$];
    logic          stall_v = 1'b0;
    logic [DW-1:0] stall_d;
    logic          stall_l;
    bit            rand_mode = 1'b0;
    exp_t          e;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reverse the bits of k by repeated halving
    function automatic int ref_rev(input int k);
        int r = 0;
        int x = k;
        for (int b = 0; b < LOG2_N; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    // Monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            part_n  = 0;
            stall_v = 1'b0;
        end else begin
            if ((s_valid && s_ready) || frm_err)
                chk("frm_err", frm_err, (s_valid && s_ready) && (s_last != (part_n == N-1)));
            if (frm_err) err_pulses++;
            if (s_valid && s_ready) begin
                last_in_cyc  = cyc;
                part[part_n] = s_data;
                part_n++;
                if (part_n == N) begin
                    for (int k = 0; k < N; k++) begin
                        e.d = part[ref_rev(k)];
                        e.l = (k == N-1);
                        exp_q.push_back(e);
                    end
                    part_n = 0;
                end
            end
            if (stall_v) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, stall_d);
                chk("stall_last", m_last, stall_l);
            end
            if (m_valid && m_ready) begin
                out_cycs.push_back(cyc);
                out_dat.push_back(m_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_last", m_last, e.l);
                end
            end
            stall_v = m_valid && !m_ready;
            stall_d = m_data;
            stall_l = m_last;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) m_ready = ($urandom_range(0, 1) == 1);
    end

    // All driver tasks start and end at posedge+1
    task automatic put(input logic [DW-1:0] d, input logic l, input int gap, output int waited);
        int n = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) chk("put_timeout", n, 0);
        waited = n;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit rnd, input logic [15:0] last_mask,
                              input int max_gap, output int waits);
        int w;
        logic [DW-1:0] d;
        waits = 0;
        for (int k = 0; k < N; k++) begin
            d = rnd ? DW'($urandom) : DW'(base + k);
            put(d, last_mask[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, w);
            waits += w;
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) chk("drain_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        int start, waits, n, c0, p;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_frm_err", frm_err, 0);
        @(posedge clk);
        #1;

        // 1: single ordered frame
        m_ready = 1'b1;
        start = out_dat.size();
        send_frame(0, 1'b0, 16'h8000, 0, waits);
        drain();
        chk("t1_count", out_dat.size() - start, 16);
        if (out_dat.size() - start == 16) begin
            chk("t1_latency", out_cycs[start] - last_in_cyc, 2);
            chk("t1_consecutive", out_cycs[start+15] - out_cycs[start], 15);
            for (int k = 0; k < N; k++) chk("t1_order", out_dat[start+k], exp_order[k]);
        end

        // 2: fill both banks with the consumer stalled
        m_ready = 1'b0;
        send_frame(100, 1'b0, 16'h8000, 0, waits);
        chk("t2_frame1_stall", waits, 0);
        send_frame(150, 1'b0, 16'h8000, 0, waits);
        chk("t2_frame2_stall", waits, 0);
        s_valid = 1'b1;
        s_data  = 16'd200;
        s_last  = 1'b0;
        @(negedge clk);
        chk("t2_sready_drop", s_ready, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t2_sready_return", n, 15);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int k = 1; k < N; k++) put(DW'(200 + k), (k == N-1), 0, waits);
        drain();

        // 3: random consumer backpressure and input gaps
        start = out_dat.size();
        rand_mode = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(0, 1'b1, 16'h8000, 2, waits);
        drain();
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        chk("t3_count", out_dat.size() - start, 64);

        // 4: full throughput
        start = out_dat.size();
        c0 = cyc;
        for (int f = 0; f < 8; f++) send_frame(1000 + f * 16, 1'b0, 16'h8000, 0, waits);
        chk("t4_in_cycles", cyc - c0, 128);
        drain();
        chk("t4_out_count", out_dat.size() - start, 128);
        if (out_dat.size() - start == 128)
            chk("t4_out_span", out_cycs[start+127] - out_cycs[start], 127);

        // 5: early s_last
        p = err_pulses;
        start = out_dat.size();
        send_frame(3000, 1'b0, 16'h8400, 0, waits);
        drain();
        chk("t5_frm_err_pulses", err_pulses - p, 1);
        chk("t5_out_count", out_dat.size() - start, 16);

        // 6: reset while writing and reading
        send_frame(4000, 1'b0, 16'h8000, 0, waits);
        for (int k = 0; k < 6; k++) put(DW'(5000 + k), 1'b0, 0, waits);
        @(negedge clk);
        chk("t6_reading", m_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_m_valid", m_valid, 0);
        chk("t6_m_last", m_last, 0);
        chk("t6_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        start = out_dat.size();
        send_frame(6000, 1'b0, 16'h8000, 0, waits);
        send_frame(7000, 1'b0, 16'h8000, 0, waits);
        chk("t6_no_stall", waits, 0);
        drain();
        chk("t6_out_count", out_dat.size() - start, 32);
        if (out_dat.size() - start == 32)
            for (int k = 0; k < N; k++) chk("t6_order", out_dat[start+k], 6000 + exp_order[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipsxe_fft_reorder_ctrl.md
# ipsxe_fft_reorder_ctrl

Ping-pong bit-reversal reorder controller for the FFT datapath. It sequences one `ipsxe_fft_distram_sdpram` instance, configured with ADDR_WIDTH = LOG2_N+1 and OUT_REG = 1, as two banks of N = 2^LOG2_N words. Each frame is written in natural order into one bank while the other bank is read out in bit-reversed order. It sits between the radix stages and the output interface; it accepts and delivers up to one sample per cycle with valid/ready handshakes on both sides.

## Interface
Parameters:
- LOG2_N, 4, log2 frame length; range 3..9.
- DATA_WIDTH, 32, sample width; passed through to the RAM.

Ports:
- clk  in  1  single clock for the block and the RAM (`wr_clk` = `rd_clk` = `clk`).
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input ready.
- s_data  in  DATA_WIDTH  input sample, natural order.
- s_last  in  1  input frame-end marker, checked only.
- m_valid  out  1  output sample valid.
- m_ready  in  1  output ready.
- m_data  out  DATA_WIDTH  equals `ram_rd_data`.
- m_last  out  1  marks the last sample of an output frame.
- frm_err  out  1  one-cycle pulse: `s_last` mismatched the write count.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  LOG2_N+1  {wr_bank, wr_cnt}.
- ram_wr_data  out  DATA_WIDTH  equals `s_data`.
- ram_rd_addr  out  LOG2_N+1  {rd_bank, bitrev(rd_cnt)}.
- ram_rd_clken  out  1  read output-register enable.
- ram_rd_data  in  DATA_WIDTH  registered RAM read data.

## Operation
- State: `full[1:0]`, `wr_bank`, `wr_cnt[LOG2_N-1:0]`, `rd_bank`, `rd_cnt[LOG2_N-1:0]`, `m_valid`, `m_last`.
- Writer:
  - `s_ready` = !full[wr_bank].
  - On a write handshake: `ram_wr_en` = 1 and `wr_cnt` increments.
  - When `wr_cnt` = N-1: set full[wr_bank], toggle `wr_bank`, and wrap `wr_cnt` to 0.
- Reader FSM:
  - RD_IDLE: stays here while full[rd_bank] = 0.
  - RD_RUN: entered when full[rd_bank] = 1.
- Read advance: `adv` = !m_valid | m_ready, and `ram_rd_clken` = `adv`.
  - In RD_RUN with `adv` = 1, a read is issued: `rd_cnt` increments.
  - On the read with `rd_cnt` = N-1: clear full[rd_bank], toggle `rd_bank`, wrap `rd_cnt`, and return to RD_IDLE (or stay in RD_RUN if the other bank is full).
  - When `adv` = 1: `m_valid` <= read-issued, and `m_last` <= (read-issued & `rd_cnt` = N-1).
  - When `adv` = 0: everything holds, including the RAM output register.
- `bitrev` reverses the LOG2_N bits of `rd_cnt`; all counters are unsigned and wrap modulo N.
- `frm_err` pulses on a write handshake when s_last ≠ (wr_cnt = N-1). The frame boundary is always set by the count; `s_last` never resynchronises it.
- Simultaneous events:
  - Setting and clearing `full` in the same cycle always targets different banks; both take effect.
  - A bank cleared by the reader becomes writable only on the following cycle, because `s_ready` uses the registered `full`.
- Reset: all counters and banks = 0; full = 00; FSM = RD_IDLE.
  - Outputs after reset: m_valid = 0, m_last = 0, frm_err = 0, s_ready = 1.
  - A partial frame in flight is discarded.

## Timing
- Input ready latency: `s_ready` is 1 in the cycle after `rst` deasserts.
- Frame latency: with the last input handshake in cycle t and `m_ready` held at 1:
  - the first read is issued in cycle t+1;
  - `m_valid` = 1 with bitrev(0) = address 0 data in cycle t+2;
  - N consecutive valid cycles follow.
- Read pipeline: one stage, the RAM output register. No additional skid stage; `m_data` holds whenever `m_valid` & !`m_ready`.
- Throughput: back-to-back frames sustain 1 sample/cycle in and out.
- Stall condition: `s_ready` drops only when both banks are full.

## Structure
- Shared package `ipsxe_fft_pkg`: RD_IDLE/RD_RUN state encoding and a `bitrev` function parameterised by width.
- The RAM is instantiated by the parent, not by this block.
- One sub-module is natural: `ipsxe_fft_reorder_bank_cnt`, the counter with terminal-count and bank toggle, instantiated twice (writer and reader).

## Test plan
All scenarios use LOG2_N = 4, DATA_WIDTH = 16, with the RAM model attached.
1. Single frame 0..15 with `m_ready` = 1 -> output order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; `m_last` only on 15; first `m_valid` two cycles after the last input beat.
2. Three back-to-back frames with `m_ready` held at 0 -> `s_ready` stays 1 through frame 2 and drops at the first beat of frame 3. Then assert `m_ready` -> `s_ready` returns exactly one cycle after frame 1's 16th read is issued.
3. Random `m_ready` (50%) over 4 frames -> no lost or duplicated samples; `m_data` and `m_last` stable while stalled.
4. Continuous `s_valid` and `m_ready` over 8 frames -> 100% throughput after the initial latency.
5. `s_last` asserted on beat 10 -> `frm_err` pulses once; the frame still completes after 16 beats.
6. `rst` asserted mid-frame during both writing and reading -> next cycle: full = 00, m_valid = 0, s_ready = 1; the following frame comes out in correct order.
